// File: rtl/panda_lsu.sv
// Load/store unit: one request at a time from the core to a synchronous-read data RAM.
// Builds RAM strobes and lane-replicated data, then aligns and extends load data.
module panda_lsu #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_unsigned_i,
  input  logic [31:0]                req_addr_i,
  input  logic [DataWidth-1:0]       req_wdata_i,
  output logic                       rsp_valid_o,
  output logic                       rsp_err_o,
  output logic [DataWidth-1:0]       rsp_rdata_o,
  output logic                       ram_ce_o,
  output logic [3:0]                 ram_we_o,
  output logic [$clog2(Depth)-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]       ram_data_o,
  input  logic [DataWidth-1:0]       ram_data_i
);

  localparam int unsigned AddrW = $clog2(Depth);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]           state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           off_q, off_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 ram_ce_q, ram_ce_d;
  logic [3:0]           ram_we_q, ram_we_d;
  logic [AddrW-1:0]     ram_addr_q, ram_addr_d;
  logic [DataWidth-1:0] ram_data_q, ram_data_d;

  logic                 accept_c;
  logic                 err_c;
  logic [DataWidth-1:0] shifted_c;
  logic [DataWidth-1:0] load_c;

  assign accept_c = req_valid_i && ready_q;

  // Request legality, evaluated on the live inputs at acceptance
  always_comb begin
    err_c = 1'b0;
    case (req_size_i)
      SZ_BYTE: err_c = 1'b0;
      SZ_HALF: err_c = req_addr_i[0];
      SZ_WORD: err_c = (req_addr_i[1:0] != 2'b00);
      default: err_c = 1'b1;
    endcase
    if (req_addr_i[31:2] >= 30'(Depth)) begin
      err_c = 1'b1;
    end
  end

  // Align the addressed lane down to bit 0 and extend to full width
  always_comb begin
    shifted_c = ram_data_i >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_c = uns_q ? {24'h0, shifted_c[7:0]}
                              : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: load_c = uns_q ? {16'h0, shifted_c[15:0]}
                              : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          we_d   = req_we_i;
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          off_d  = req_addr_i[1:0];
          if (err_c) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = S_ACCESS;
            ram_ce_d   = 1'b1;
            ram_addr_d = req_addr_i[2 +: AddrW];
            case (req_size_i)
              SZ_BYTE: begin
                ram_we_d   = req_we_i ? (4'b0001 << req_addr_i[1:0]) : 4'b0000;
                ram_data_d = {4{req_wdata_i[7:0]}};
              end
              SZ_HALF: begin
                ram_we_d   = req_we_i ? (4'b0011 << req_addr_i[1:0]) : 4'b0000;
                ram_data_d = {2{req_wdata_i[15:0]}};
              end
              default: begin
                ram_we_d   = req_we_i ? 4'b1111 : 4'b0000;
                ram_data_d = req_wdata_i;
              end
            endcase
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d     = S_RESP;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d     = S_RESP;
        rsp_rdata_d = load_c;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rsp_valid_d = (state_d == S_RESP);
    ready_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu with a behavioural synchronous-read RAM attached.
module tb_panda_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        ram_ce_o;
  logic [3:0]  ram_we_o;
  logic [5:0]  ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_rdata;

  logic        mem_clear = 1'b1;
  logic [31:0] mem [64];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  panda_lsu #(.DataWidth(32), .Depth(64)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_err_o      (rsp_err_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .ram_ce_o       (ram_ce_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_rdata)
  );

  // RAM: word i preloads to 0x12345600+i; read data appears the cycle after ce
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1234_5600 + 32'(i);
      ram_rdata <= 32'h0;
    end else if (ram_ce_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
      ram_rdata <= mem[ram_addr_o];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE and returns 1ns after the accepting edge
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_valid_i    = 1'b1;
    step();
    req_valid_i    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h want=1", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h want=0", rsp_valid_o); end
    checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h want=0", rsp_err_o); end
    checks++; if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h want=0", rsp_rdata_o); end
    checks++; if (ram_ce_o !== 1'b0) begin failures++; $display("FAIL rst_ce got=%0h want=0", ram_ce_o); end
    checks++; if (ram_we_o !== 4'h0) begin failures++; $display("FAIL rst_we got=%0h want=0", ram_we_o); end
    checks++; if (ram_addr_o !== 6'h0) begin failures++; $display("FAIL rst_addr got=%0h want=0", ram_addr_o); end
    checks++; if (ram_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%0h want=0", ram_data_o); end
  endtask

  task automatic test_word();
    issue(1'b1, 2'b10, 1'b0, 32'hA0, 32'hABCDEF89);
    checks++; if (ram_ce_o !== 1'b1) begin failures++; $display("FAIL wst_ce got=%0h want=1", ram_ce_o); end
    checks++; if (ram_we_o !== 4'b1111) begin failures++; $display("FAIL wst_we got=%0h want=f", ram_we_o); end
    checks++; if (ram_addr_o !== 6'd40) begin failures++; $display("FAIL wst_addr got=%0d want=40", ram_addr_o); end
    checks++; if (ram_data_o !== 32'hABCDEF89) begin failures++; $display("FAIL wst_data got=%0h want=abcdef89", ram_data_o); end
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL wst_ready got=%0h want=0", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wst_early got=%0h want=0", rsp_valid_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL wst_valid got=%0h want=1", rsp_valid_o); end
    checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL wst_err got=%0h want=0", rsp_err_o); end
    checks++; if (ram_ce_o !== 1'b0) begin failures++; $display("FAIL wst_ce_off got=%0h want=0", ram_ce_o); end
    checks++; if (ram_addr_o !== 6'd40) begin failures++; $display("FAIL wst_addr_hold got=%0d want=40", ram_addr_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL wst_idle got=%0h/%0h want=0/1", rsp_valid_o, req_ready_o); end
    issue(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
    checks++; if (ram_ce_o !== 1'b1 || ram_we_o !== 4'h0) begin failures++; $display("FAIL wld_ce got=%0h/%0h want=1/0", ram_ce_o, ram_we_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wld_early got=%0h want=0", rsp_valid_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL wld_valid got=%0h want=1", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'hABCDEF89) begin failures++; $display("FAIL wld_rdata got=%0h want=abcdef89", rsp_rdata_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL wld_pulse got=%0h want=0", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'hABCDEF89) begin failures++; $display("FAIL wld_hold got=%0h want=abcdef89", rsp_rdata_o); end
  endtask

  task automatic test_byte();
    issue(1'b1, 2'b00, 1'b0, 32'hA6, 32'h1234_5689);
    checks++; if (ram_we_o !== 4'b0100) begin failures++; $display("FAIL bst_we got=%0h want=4", ram_we_o); end
    checks++; if (ram_data_o !== 32'h89898989) begin failures++; $display("FAIL bst_data got=%0h want=89898989", ram_data_o); end
    checks++; if (ram_addr_o !== 6'd41) begin failures++; $display("FAIL bst_addr got=%0d want=41", ram_addr_o); end
    step(); step();
    issue(1'b0, 2'b00, 1'b0, 32'hA6, 32'h0);
    step(); step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFFFF89) begin failures++; $display("FAIL bld_s got=%0h/%0h want=1/ffffff89", rsp_valid_o, rsp_rdata_o); end
    step();
    issue(1'b0, 2'b00, 1'b1, 32'hA6, 32'h0);
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    step(); step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h00000089) begin failures++; $display("FAIL bld_u got=%0h/%0h want=1/89", rsp_valid_o, rsp_rdata_o); end
    step();
    issue(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0);
    step(); step();
    checks++; if (rsp_rdata_o !== 32'h12895629) begin failures++; $display("FAIL bst_lanes got=%0h want=12895629", rsp_rdata_o); end
    step();
  endtask

  task automatic test_half();
    issue(1'b1, 2'b01, 1'b0, 32'hA6, 32'h5555_EF89);
    checks++; if (ram_we_o !== 4'b1100) begin failures++; $display("FAIL hst_we got=%0h want=c", ram_we_o); end
    checks++; if (ram_data_o !== 32'hEF89EF89) begin failures++; $display("FAIL hst_data got=%0h want=ef89ef89", ram_data_o); end
    step(); step();
    issue(1'b0, 2'b01, 1'b0, 32'hA6, 32'h0);
    step(); step();
    checks++; if (rsp_rdata_o !== 32'hFFFFEF89) begin failures++; $display("FAIL hld_s got=%0h want=ffffef89", rsp_rdata_o); end
    step();
    issue(1'b0, 2'b01, 1'b1, 32'hA6, 32'h0);
    step(); step();
    checks++; if (rsp_rdata_o !== 32'h0000EF89) begin failures++; $display("FAIL hld_u got=%0h want=ef89", rsp_rdata_o); end
    step();
    issue(1'b0, 2'b01, 1'b0, 32'hA4, 32'h0);
    step(); step();
    checks++; if (rsp_rdata_o !== 32'h00005629) begin failures++; $display("FAIL hld_lo got=%0h want=5629", rsp_rdata_o); end
    step();
  endtask

  task automatic test_errors();
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin we = 1'b0; sz = 2'b10; addr = 32'hA1;  end
        1:       begin we = 1'b1; sz = 2'b01; addr = 32'hA3;  end
        2:       begin we = 1'b0; sz = 2'b11; addr = 32'hA0;  end
        default: begin we = 1'b0; sz = 2'b10; addr = 32'h100; end
      endcase
      issue(we, sz, 1'b0, addr, 32'hFFFF_FFFF);
      checks++; if (ram_ce_o !== 1'b0 || ram_we_o !== 4'h0) begin failures++; $display("FAIL err%0d_ce got=%0h/%0h want=0/0", i, ram_ce_o, ram_we_o); end
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin failures++; $display("FAIL err%0d_rsp got=%0h/%0h want=1/1", i, rsp_valid_o, rsp_err_o); end
      checks++; if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL err%0d_rdata got=%0h want=0", i, rsp_rdata_o); end
      step();
      checks++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1 || ram_ce_o !== 1'b0) begin failures++; $display("FAIL err%0d_after got=%0h/%0h/%0h/%0h want=0/0/1/0", i, rsp_valid_o, rsp_err_o, req_ready_o, ram_ce_o); end
    end
  endtask

  task automatic test_boundary();
    issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    checks++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 6'd63) begin failures++; $display("FAIL top_ce got=%0h/%0d want=1/63", ram_ce_o, ram_addr_o); end
    step(); step();
    checks++; if (rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1234563F) begin failures++; $display("FAIL top_rdata got=%0h/%0h want=0/1234563f", rsp_err_o, rsp_rdata_o); end
    step();
  endtask

  task automatic test_back_to_back();
    req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0; req_addr_i = 32'hA0;
    req_valid_i = 1'b1;
    step();
    checks++; if (req_ready_o !== 1'b0 || ram_addr_o !== 6'd40) begin failures++; $display("FAIL b2b_c1 got=%0h/%0d want=0/40", req_ready_o, ram_addr_o); end
    step();
    checks++; if (req_ready_o !== 1'b0 || ram_ce_o !== 1'b0) begin failures++; $display("FAIL b2b_c2 got=%0h/%0h want=0/0", req_ready_o, ram_ce_o); end
    step();
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_c3 got=%0h want=0", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hABCDEF89) begin failures++; $display("FAIL b2b_rsp1 got=%0h/%0h want=1/abcdef89", rsp_valid_o, rsp_rdata_o); end
    req_size_i = 2'b00; req_unsigned_i = 1'b1; req_addr_i = 32'hA7;
    step();
    checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || ram_ce_o !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0h/%0h/%0h want=1/0/0", req_ready_o, rsp_valid_o, ram_ce_o); end
    step();
    req_valid_i = 1'b0;
    checks++; if (req_ready_o !== 1'b0 || ram_ce_o !== 1'b1 || ram_addr_o !== 6'd41) begin failures++; $display("FAIL b2b_acc2 got=%0h/%0h/%0d want=0/1/41", req_ready_o, ram_ce_o, ram_addr_o); end
    step(); step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h000000EF) begin failures++; $display("FAIL b2b_rsp2 got=%0h/%0h want=1/ef", rsp_valid_o, rsp_rdata_o); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    test_reset();
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rmw_valid got=%0h want=0", rsp_valid_o); end
    rst_n = 1'b1;
    step();
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL rmw_after got=%0h/%0h want=0/1", rsp_valid_o, req_ready_o); end

    issue(1'b1, 2'b10, 1'b0, 32'hA0, 32'hDEADBEEF);
    checks++; if (ram_ce_o !== 1'b1) begin failures++; $display("FAIL rms_pre got=%0h want=1", ram_ce_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_ce_o !== 1'b0 || ram_we_o !== 4'h0 || ram_data_o !== 32'h0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL rms_async got=%0h/%0h/%0h/%0h want=0/0/0/1", ram_ce_o, ram_we_o, ram_data_o, req_ready_o); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rms_valid got=%0h want=0", rsp_valid_o); end
    issue(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
    step(); step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hABCDEF89) begin failures++; $display("FAIL rms_old got=%0h/%0h want=1/abcdef89", rsp_valid_o, rsp_rdata_o); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    mem_clear = 1'b0;
    rst_n = 1'b1;
    step();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
